// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, default line timing and
// the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_WAIT_FIRST,
    S_SHIFT,
    S_ACK_WAIT,
    S_DONE,
    S_FAIL
  } ps2_state_e;

  // Defaults assume a 25 MHz clk25.
  localparam int unsigned INHIBIT_CYCLES_DEF     = 3000;    // 120 us
  localparam int unsigned FIRST_EDGE_TIMEOUT_DEF = 375000;  // 15 ms
  localparam int unsigned PACKET_TIMEOUT_DEF     = 50000;   // 2 ms
  localparam int unsigned FILTER_LEN_DEF         = 8;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus level filter: the output only follows the line
// after FILTER_LEN consecutive synchronised samples at the new level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk25,
  input  logic reset,
  input  logic line_in,
  output logic line_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    sync_d = {sync_q[0], line_in};
    cnt_d  = '0;
    filt_d = filt_q;
    // Any sample matching the current output restarts the run count.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == C_LAST) filt_d = sync_q[1];
      else                 cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES     = INHIBIT_CYCLES_DEF,
  parameter int unsigned FIRST_EDGE_TIMEOUT = FIRST_EDGE_TIMEOUT_DEF,
  parameter int unsigned PACKET_TIMEOUT     = PACKET_TIMEOUT_DEF,
  parameter int unsigned FILTER_LEN         = FILTER_LEN_DEF
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // One timer serves inhibit, first-edge and packet phases, which never overlap.
  localparam int unsigned TMAX_A = (FIRST_EDGE_TIMEOUT > PACKET_TIMEOUT) ?
                                   FIRST_EDGE_TIMEOUT : PACKET_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > INHIBIT_CYCLES) ? TMAX_A : INHIBIT_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_SAT   = TW'(TMAX);
  localparam logic [TW-1:0] T_INH   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] T_FIRST = TW'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [TW-1:0] T_PKT   = TW'(PACKET_TIMEOUT - 1);

  logic clk_filt, data_filt, fall_edge;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk25   (clk25),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .line_o  (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk25   (clk25),
    .reset   (reset),
    .line_in (ps2_data_in),
    .line_o  (data_filt)
  );

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    n_q, n_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          tx_ready_q, tx_ready_d;
  logic          busy_q, busy_d;
  logic          clk_prev_q, clk_prev_d;
  logic          fail_now;

  assign clk_prev_d = clk_filt;
  assign fall_edge  = clk_prev_q & ~clk_filt;

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
    n_d       = n_q;
    data_d    = data_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail_now  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d   = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == T_INH) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        clk_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (fall_edge) begin
          data_oe_d = ~data_q[0];
          n_d       = 4'd1;
          timer_d   = '0;
          state_d   = S_SHIFT;
        end else if (timer_q == T_FIRST) begin
          fail_now = 1'b1;
        end
      end
      S_SHIFT: begin
        if (timer_q == T_PKT) begin
          fail_now = 1'b1;
        end else if (fall_edge) begin
          n_d = n_q + 4'd1;
          // n counts falls already seen; the 11th fall samples the ACK.
          if (n_q <= 4'd7)      data_oe_d = ~data_q[n_q[2:0]];
          else if (n_q == 4'd8) data_oe_d = ~par_q;
          else if (n_q == 4'd9) data_oe_d = 1'b0;
          else if (data_filt)   fail_now  = 1'b1;
          else                  state_d   = S_ACK_WAIT;
        end
      end
      S_ACK_WAIT: begin
        if (timer_q == T_PKT) begin
          fail_now = 1'b1;
        end else if (clk_filt && data_filt) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fail_now) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
      state_d   = S_FAIL;
    end
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = ~tx_ready_d;
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      n_q        <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      n_q        <= n_d;
      data_q     <= data_d;
      par_q      <= par_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign rx_inhibit  = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host; frame content and done/error outcome come from a byte-level model.
module tb_ps2_host_tx;

  localparam int INH = 500;
  localparam int FET = 1000;
  localparam int PKT = 50000;
  localparam int FL  = 8;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, error, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain wired lines with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .FIRST_EDGE_TIMEOUT(FET),
    .PACKET_TIMEOUT(PKT), .FILTER_LEN(FL)
  ) dut (
    .clk25(clk25), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #20 clk25 = ~clk25;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_run = 0, last_run = 0;

  always @(negedge clk25) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) oe_run <= oe_run + 1;
    else if (oe_run != 0) begin
      last_run <= oe_run;
      oe_run   <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  // Expected pull-down pattern: bit0..bit7, odd parity, released stop bit.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones = 0;
    for (int k = 0; k < 8; k++) begin
      f[k] = !b[k];
      ones += int'(b[k]);
    end
    f[8] = (ones % 2 == 1);
    f[9] = 1'b0;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    chk("tx_ready_idle", int'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data  = b;
    step(1);
    chk("busy_after_accept", int'(busy), 1);
    tx_data = ~b;  // must be ignored while busy
    step(2);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rts();
    int t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < INH + 100) begin
      step(1);
      t++;
    end
    chk("rts_seen", int'(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1), 1);
    chk("rx_inhibit_busy", int'(rx_inhibit), 1);
  endtask

  // Device: 11 clock pulses, records host pull-down at the end of each low phase.
  task automatic device(input int half, input bit ack, input int glitch_ph,
                        input int rst_ph, output logic [9:0] seen);
    seen = '0;
    wait_rts();
    for (int i = 0; i <= 10; i++) begin
      if (i == 0) step(50);
      else if (i == glitch_ph) begin
        step(half / 2);
        dev_clk_low = 1'b1;
        step(3);
        dev_clk_low = 1'b0;
        step(half - half / 2 - 3);
      end else if (i == 10 && ack) begin
        step(half / 2);
        dev_data_low = 1'b1;
        step(half - half / 2);
      end else step(half);
      dev_clk_low = 1'b1;
      if (i == rst_ph) begin
        step(15);
        chk("pre_rst_data_oe", int'(ps2_data_oe), 1);
        #5 reset = 1'b1;
        #1;
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ps2_data_oe), 0);
        dev_clk_low = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        return;
      end
      step(half - 1);
      if (i < 10) seen[i] = ps2_data_oe;
      step(1);
      dev_clk_low = 1'b0;
    end
    step(half / 2);
    dev_data_low = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         half;
    bit         exp_done;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #(40 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0] seen;
    int bd, be, t;

    vecs[0] = '{8'hED, 1'b1, 1000, 1'b1};  // 12.5 kHz device clock
    vecs[1] = '{8'hF4, 1'b1, 20, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 25, 1'b0};    // device withholds ACK
    for (int k = 3; k < 9; k++) begin
      vecs[k].data     = 8'($urandom);
      vecs[k].ack      = 1'($urandom_range(0, 1));
      vecs[k].half     = int'($urandom_range(20, 40));
      vecs[k].exp_done = vecs[k].ack;
    end

    step(3);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    reset = 1'b0;
    step(2);
    chk("idle_flags", int'({done, error, rx_inhibit}), 0);

    foreach (vecs[k]) begin
      bd = done_cnt;
      be = err_cnt;
      start_tx(vecs[k].data);
      device(vecs[k].half, vecs[k].ack, -1, -1, seen);
      t = 0;
      while (done_cnt == bd && err_cnt == be && t < 300) begin
        step(1);
        t++;
      end
      step(3);
      chk($sformatf("frame[%0d]", k), int'(seen), int'(exp_frame(vecs[k].data)));
      chk($sformatf("inhibit_len[%0d]", k), last_run, INH + 1);
      chk($sformatf("done[%0d]", k), done_cnt - bd, int'(vecs[k].exp_done));
      chk($sformatf("error[%0d]", k), err_cnt - be, int'(!vecs[k].exp_done));
      chk($sformatf("released[%0d]", k), int'({ps2_clk_oe, ps2_data_oe}), 0);
      chk($sformatf("ready_after[%0d]", k), int'(tx_ready), 1);
    end

    // Device never clocks: error FET cycles after clock release.
    bd = done_cnt;
    start_tx(8'hA5);
    wait_rts();
    t = 0;
    while (!error && t < 2 * FET) begin
      step(1);
      t++;
    end
    chk("timeout_cycles", t, FET);
    chk("timeout_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    step(1);
    chk("timeout_ready", int'(tx_ready), 1);
    chk("timeout_no_done", done_cnt - bd, 0);

    // 3-cycle clock glitch mid-frame must not count as an edge.
    bd = done_cnt;
    be = err_cnt;
    start_tx(8'h96);
    device(30, 1'b1, 3, -1, seen);
    step(40);
    chk("glitch_frame", int'(seen), int'(exp_frame(8'h96)));
    chk("glitch_done", done_cnt - bd, 1);
    chk("glitch_error", err_cnt - be, 0);

    // Reset after the 4th falling edge.
    bd = done_cnt;
    be = err_cnt;
    start_tx(8'h55);
    device(30, 1'b1, -1, 3, seen);
    chk("post_rst_ready", int'(tx_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    step(200);
    chk("post_rst_no_done", done_cnt - bd, 0);
    chk("post_rst_no_error", err_cnt - be, 0);

    chk("never_both", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
